// File: rtl/um_tsn_classifier.sv
// um_tsn_classifier
//   Store-and-forward packet stage of the OpenTSN user module. Each packet is
//   classified on destination MAC and 802.1Q PCP (taken from word 2), and
//   metadata word 0 is rewritten with an output-port field ([119:108]) and the
//   priority/vlan bits ([79:76]) before entering a word FIFO. The write side
//   commits a packet at its tail when it was flagged good, otherwise the write
//   pointer rolls back so the packet is never read out.
//
// Ports
//   clk, rst_n            clock; synchronous reset, active HIGH despite the name
//   pktin_*               ingress word bus, good flag sampled with the tail
//   pktin_ready           ingress may start a new packet (free >= READY_TH)
//   pktout_*              egress word bus, honours pktout_ready per word
//   um_timer              free-running cycle counter
//   dma / match / ctrl    compatibility ports, inputs ignored, outputs tied
module um_tsn_classifier #(
  parameter logic [47:0] DIRECT_MAC = 48'h000a35000001,
  parameter logic [47:0] LOCAL_MAC  = 48'h0023cd76631a,
  parameter logic [11:0] OUT_PORT   = 12'h001,
  parameter int unsigned FIFO_AW    = 9,
  parameter int unsigned READY_TH   = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pktin_data_wr,
  input  logic [133:0] pktin_data,
  input  logic         pktin_data_valid,
  input  logic         pktin_data_valid_wr,
  output logic         pktin_ready,
  output logic         pktout_data_wr,
  output logic [133:0] pktout_data,
  output logic         pktout_data_valid,
  output logic         pktout_data_valid_wr,
  input  logic         pktout_ready,
  input  logic [63:0]  um_timestamp,
  input  logic [133:0] dma2um_data,
  input  logic         dma2um_data_wr,
  output logic         um2dma_ready,
  output logic [133:0] um2dma_data,
  output logic         um2dma_data_wr,
  input  logic         dma2um_ready,
  output logic         um2me_key_wr,
  output logic         um2me_key_valid,
  output logic [511:0] um2match_key,
  input  logic         um2me_ready,
  input  logic         me2um_id_wr,
  input  logic [15:0]  match2um_id,
  output logic         um2match_gme_alful,
  input  logic         ctrl_valid,
  input  logic         ctrl2um_cs_n,
  output logic         um2ctrl_ack_n,
  input  logic [1:0]   ctrl_cmd,
  input  logic [31:0]  ctrl_datain,
  input  logic [31:0]  ctrl_addr,
  output logic [31:0]  ctrl_dataout,
  output logic [63:0]  um_timer
);

  // Compatibility tie-offs
  assign um2dma_ready       = 1'b1;
  assign um2dma_data        = '0;
  assign um2dma_data_wr     = 1'b0;
  assign um2me_key_wr       = 1'b0;
  assign um2me_key_valid    = 1'b0;
  assign um2match_key       = '0;
  assign um2match_gme_alful = 1'b0;
  assign um2ctrl_ack_n      = 1'b1;
  assign ctrl_dataout       = '0;

  logic unused_inputs;
  assign unused_inputs = ^{um_timestamp, dma2um_data, dma2um_data_wr, dma2um_ready,
                           um2me_ready, me2um_id_wr, match2um_id, ctrl_valid,
                           ctrl2um_cs_n, ctrl_cmd, ctrl_datain, ctrl_addr};

  logic [133:0]       mem [0:(2**FIFO_AW)-1];
  logic [FIFO_AW-1:0] wr_ptr, cmt_ptr, rd_ptr;
  logic [FIFO_AW:0]   pkt_cnt;
  logic               ovf;

  // Word index within the packet: 0 at head, saturates at 3
  logic [1:0]  idx;
  logic [11:0] cls_out;
  logic [2:0]  cls_pcp;
  logic        cls_vlan;

  // Three-stage delay line: word 0 reaches the FIFO write port exactly one
  // cycle after word 2 was sampled, so the classification registered from
  // word 2 is ready for the rewrite. All later words keep the same spacing,
  // which removes any need to insert words into a running stream.
  logic [2:0]   st_v, st_head, st_tail, st_good;
  logic [133:0] st_data [0:2];

  logic head_in, tail_in, good_in;
  assign head_in = pktin_data[133:132] == 2'b01;
  assign tail_in = pktin_data[133:132] == 2'b10;
  assign good_in = pktin_data_valid_wr & pktin_data_valid;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      st_v    <= '0;
      st_head <= '0;
      st_tail <= '0;
      st_good <= '0;
    end else begin
      st_v    <= {st_v[1:0], pktin_data_wr};
      st_head <= {st_head[1:0], pktin_data_wr & head_in};
      st_tail <= {st_tail[1:0], pktin_data_wr & tail_in};
      st_good <= {st_good[1:0], good_in};
    end
  end

  always_ff @(posedge clk) begin
    st_data[0] <= pktin_data;
    st_data[1] <= st_data[0];
    st_data[2] <= st_data[1];
  end

  // Classification. A head resets to the "no word 2" defaults so packets
  // shorter than three words go out as unknown/untagged.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      idx      <= 2'd3;
      cls_out  <= 12'hFFF;
      cls_pcp  <= '0;
      cls_vlan <= 1'b0;
    end else if (pktin_data_wr) begin
      if (head_in) begin
        idx      <= 2'd1;
        cls_out  <= 12'hFFF;
        cls_pcp  <= '0;
        cls_vlan <= 1'b0;
      end else if (idx == 2'd2) begin
        idx <= 2'd3;
        if (pktin_data[127:80] == DIRECT_MAC)
          cls_out <= OUT_PORT;
        else if (pktin_data[127:80] == LOCAL_MAC)
          cls_out <= 12'h000;
        else
          cls_out <= 12'hFFF;
        cls_vlan <= pktin_data[31:16] == 16'h8100;
        cls_pcp  <= (pktin_data[31:16] == 16'h8100) ? pktin_data[15:13] : 3'd0;
      end else if (idx != 2'd3) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // FIFO write side with commit / rollback
  logic [133:0]       wr_word;
  logic [FIFO_AW-1:0] used;
  logic               full, wr_ok, commit;

  assign wr_word = st_head[2]
                 ? {st_data[2][133:120], cls_out, st_data[2][107:80],
                    cls_pcp, cls_vlan, st_data[2][75:0]}
                 : st_data[2];
  assign used    = wr_ptr - rd_ptr;
  assign full    = (wr_ptr + 1'b1) == rd_ptr;
  assign wr_ok   = st_v[2] && !ovf && !full;
  assign commit  = wr_ok && st_tail[2] && st_good[2];

  always_ff @(posedge clk) begin
    if (!rst_n && wr_ok)
      mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      ovf     <= 1'b0;
    end else if (st_v[2]) begin
      if (st_tail[2]) begin
        ovf <= 1'b0;
        if (commit) begin
          wr_ptr  <= wr_ptr + 1'b1;
          cmt_ptr <= wr_ptr + 1'b1;
        end else begin
          wr_ptr <= cmt_ptr;
        end
      end else if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  logic [FIFO_AW:0] free_words;
  assign free_words = {1'b0, {FIFO_AW{1'b1}}} - {1'b0, used};

  always_ff @(posedge clk) begin
    if (rst_n)
      pktin_ready <= 1'b1;
    else
      pktin_ready <= free_words >= (FIFO_AW+1)'(READY_TH);
  end

  // Read side: words flow whenever a committed packet exists; the packet
  // counter drops on the tail word, so reading stops exactly at packet ends.
  logic rd_en, rd_tail;
  assign rd_en   = pktout_ready && (pkt_cnt != '0);
  assign rd_tail = mem[rd_ptr][133:132] == 2'b10;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({commit, rd_en && rd_tail})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_ptr               <= '0;
      pktout_data          <= '0;
      pktout_data_wr       <= 1'b0;
      pktout_data_valid    <= 1'b0;
      pktout_data_valid_wr <= 1'b0;
    end else if (rd_en) begin
      rd_ptr               <= rd_ptr + 1'b1;
      pktout_data          <= mem[rd_ptr];
      pktout_data_wr       <= 1'b1;
      pktout_data_valid    <= rd_tail;
      pktout_data_valid_wr <= rd_tail;
    end else begin
      pktout_data_wr       <= 1'b0;
      pktout_data_valid    <= 1'b0;
      pktout_data_valid_wr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      um_timer <= '0;
    else
      um_timer <= um_timer + 64'd1;
  end

endmodule

// File: tb/tb_um_tsn_classifier.sv
// Testbench for um_tsn_classifier: directed packets, expected words queued at
// issue time, compared by an independent output monitor.
module tb_um_tsn_classifier;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         pktin_data_wr;
  logic [133:0] pktin_data;
  logic         pktin_data_valid;
  logic         pktin_data_valid_wr;
  logic         pktin_ready;
  logic         pktout_data_wr;
  logic [133:0] pktout_data;
  logic         pktout_data_valid;
  logic         pktout_data_valid_wr;
  logic         pktout_ready;
  logic [133:0] um2dma_data;
  logic         um2dma_ready, um2dma_data_wr;
  logic         um2me_key_wr, um2me_key_valid, um2match_gme_alful;
  logic [511:0] um2match_key;
  logic         um2ctrl_ack_n;
  logic [31:0]  ctrl_dataout;
  logic [63:0]  um_timer;

  um_tsn_classifier dut (
    .clk(clk), .rst_n(rst_n),
    .pktin_data_wr(pktin_data_wr), .pktin_data(pktin_data),
    .pktin_data_valid(pktin_data_valid), .pktin_data_valid_wr(pktin_data_valid_wr),
    .pktin_ready(pktin_ready),
    .pktout_data_wr(pktout_data_wr), .pktout_data(pktout_data),
    .pktout_data_valid(pktout_data_valid), .pktout_data_valid_wr(pktout_data_valid_wr),
    .pktout_ready(pktout_ready),
    .um_timestamp(64'h0123_4567_89ab_cdef),
    .dma2um_data('0), .dma2um_data_wr(1'b0),
    .um2dma_ready(um2dma_ready), .um2dma_data(um2dma_data), .um2dma_data_wr(um2dma_data_wr),
    .dma2um_ready(1'b1),
    .um2me_key_wr(um2me_key_wr), .um2me_key_valid(um2me_key_valid),
    .um2match_key(um2match_key), .um2me_ready(1'b1),
    .me2um_id_wr(1'b0), .match2um_id(16'h0), .um2match_gme_alful(um2match_gme_alful),
    .ctrl_valid(1'b0), .ctrl2um_cs_n(1'b1), .um2ctrl_ack_n(um2ctrl_ack_n),
    .ctrl_cmd(2'b00), .ctrl_datain(32'h0), .ctrl_addr(32'h0),
    .ctrl_dataout(ctrl_dataout), .um_timer(um_timer)
  );

  localparam logic [47:0] DIRECT = 48'h000a35000001;
  localparam logic [47:0] LOCAL  = 48'h0023cd76631a;

  int applied     = 0;
  int miscompares = 0;
  int out_words   = 0;

  logic [134:0] exp_q [$];
  logic [133:0] pkt [$];
  logic [134:0] mon_e;
  logic         watch_ready = 1'b0;
  logic         ready_dropped = 1'b0;

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Output monitor
  always @(negedge clk) begin
    if (pktout_data_wr === 1'b1) begin
      out_words++;
      if (exp_q.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_word: got %h required no output", pktout_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", pktout_data, mon_e[133:0]);
        check1("out_valid_wr", pktout_data_valid_wr, mon_e[134]);
        check1("out_valid", pktout_data_valid, mon_e[134]);
      end
    end else if (pktout_data_valid_wr === 1'b1) begin
      check1("stray_valid_wr", pktout_data_valid_wr, 1'b0);
    end
    if (watch_ready && pktin_ready !== 1'b1)
      ready_dropped = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [127:0] m0, input logic [47:0] dmac,
                       input logic [15:0] tpid, input logic [15:0] tci,
                       input int n, input logic [31:0] tag);
    logic [133:0] w;
    pkt.delete();
    pkt.push_back({2'b01, 4'h0, m0});
    pkt.push_back({2'b11, 4'h0, tag, 96'h0});
    pkt.push_back({2'b11, 4'h0, dmac, 48'h0023cd76631a, tpid, tci});
    for (int k = 3; k < n; k++)
      pkt.push_back({2'b11, 4'h0, tag, 32'(k), 64'h0123456789abcdef});
    while (pkt.size() > n) void'(pkt.pop_back());
    w = pkt[pkt.size()-1];
    w[133:128] = {2'b10, 4'h2};
    pkt[pkt.size()-1] = w;
  endtask

  task automatic send_pkt(input logic [133:0] exp_w0, input bit good, input int gap);
    if (good)
      for (int i = 0; i < pkt.size(); i++)
        exp_q.push_back({i == pkt.size()-1, (i == 0) ? exp_w0 : pkt[i]});
    for (int i = 0; i < pkt.size(); i++) begin
      pktin_data_wr       = 1'b1;
      pktin_data          = pkt[i];
      pktin_data_valid_wr = (i == pkt.size()-1);
      pktin_data_valid    = (i == pkt.size()-1) && good;
      tick();
    end
    pktin_data_wr       = 1'b0;
    pktin_data_valid_wr = 1'b0;
    pktin_data_valid    = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    applied++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d words still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) tick();
  endtask

  // Hand-computed word 0 images
  localparam logic [127:0] EX_M0    = 128'h00ABC06e0001F8000000000000000000;
  localparam logic [133:0] EX_W0    = {2'b01, 4'h0, 128'h0000106e000198000000000000000000};
  localparam logic [127:0] LOC_M0   = 128'h0512304022117777000000000000abcd;
  localparam logic [133:0] LOC_W0   = {2'b01, 4'h0, 128'h0500004022110777000000000000abcd};
  localparam logic [127:0] UNK_M0   = 128'h00000080030200000000000000000000;
  localparam logic [133:0] UNK_W0   = {2'b01, 4'h0, 128'h00FFF0800302F0000000000000000000};
  localparam logic [127:0] SHORT_M0 = 128'h00000020000000000000000000000000;
  localparam logic [133:0] SHORT_W0 = {2'b01, 4'h0, 128'h00FFF020000000000000000000000000};

  initial begin
    int cyc;
    int saved;
    bit low_seen;

    rst_n = 1'b1;
    pktin_data_wr = 1'b0;
    pktin_data = '0;
    pktin_data_valid = 1'b0;
    pktin_data_valid_wr = 1'b0;
    pktout_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check1("rst_out_wr", pktout_data_wr, 1'b0);
    check("rst_out_data", pktout_data, '0);
    check1("rst_valid_wr", pktout_data_valid_wr, 1'b0);
    check1("rst_ready", pktin_ready, 1'b1);
    check("rst_timer", {70'h0, um_timer}, 134'd0);
    check1("tie_dma_ready", um2dma_ready, 1'b1);
    check1("tie_ack_n", um2ctrl_ack_n, 1'b1);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("timer_count", {70'h0, um_timer}, 134'd10);
    tick();

    // Example packet: DIRECT_MAC, PCP 4
    build(EX_M0, DIRECT, 16'h8100, 16'h8005, 7, 32'h1);
    send_pkt(EX_W0, 1'b1, 2);
    wait_drain("example_drain", 100);

    // 50 back-to-back copies
    watch_ready = 1'b1;
    for (int i = 0; i < 50; i++) send_pkt(EX_W0, 1'b1, 2);
    watch_ready = 1'b0;
    wait_drain("b2b_drain", 500);
    check1("b2b_ready_held", ready_dropped, 1'b0);

    // Bad packet then good packet
    build(EX_M0, DIRECT, 16'h8100, 16'h8005, 7, 32'hBAD0);
    send_pkt(EX_W0, 1'b0, 2);
    build(EX_M0, DIRECT, 16'h8100, 16'h8005, 6, 32'h600D);
    send_pkt(EX_W0, 1'b1, 2);
    wait_drain("drop_drain", 100);

    // LOCAL_MAC untagged, unknown DMAC tagged, short packet after a hit
    build(LOC_M0, LOCAL, 16'h0800, 16'h4500, 5, 32'h10C);
    send_pkt(LOC_W0, 1'b1, 2);
    build(UNK_M0, 48'h112233445566, 16'h8100, 16'hE00A, 4, 32'h0BAD);
    send_pkt(UNK_W0, 1'b1, 2);
    build(EX_M0, DIRECT, 16'h8100, 16'h8005, 3, 32'h3);
    send_pkt(EX_W0, 1'b1, 0);
    build(SHORT_M0, DIRECT, 16'h8100, 16'hE000, 2, 32'h2);
    send_pkt(SHORT_W0, 1'b1, 2);
    wait_drain("class_drain", 100);

    // Egress stalled for 700 cycles while packets stream in
    pktout_ready = 1'b0;
    saved = out_words;
    cyc = 0;
    low_seen = 1'b0;
    while (cyc < 700) begin
      if (pktin_ready) begin
        build(EX_M0, DIRECT, 16'h8100, 16'h8005, 7, 32'(cyc));
        send_pkt(EX_W0, 1'b1, 2);
        cyc += 9;
      end else begin
        low_seen = 1'b1;
        tick();
        cyc++;
      end
    end
    check1("stall_ready_low", low_seen, 1'b1);
    check("stall_no_output", 134'(out_words - saved), 134'd0);
    pktout_ready = 1'b1;
    wait_drain("stall_drain", 2000);
    check1("stall_ready_back", pktin_ready, 1'b1);

    // Reset mid-packet
    build(EX_M0, DIRECT, 16'h8100, 16'h8005, 7, 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      pktin_data_wr = 1'b1;
      pktin_data    = pkt[i];
      tick();
    end
    pktin_data_wr = 1'b0;
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    saved = out_words;
    repeat (20) tick();
    check("midrst_no_output", 134'(out_words - saved), 134'd0);
    check1("midrst_ready", pktin_ready, 1'b1);
    build(EX_M0, DIRECT, 16'h8100, 16'h8005, 7, 32'hF00D);
    send_pkt(EX_W0, 1'b1, 2);
    wait_drain("midrst_drain", 100);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/um_tsn_classifier.md
Name: um_tsn_classifier

Overview:
User-module packet stage between the port/CPU ingress bus and the egress bus of the OpenTSN switch datapath. It classifies each packet by destination MAC and 802.1Q PCP, then rewrites metadata word 0 with an output-port field and the priority. Packets are stored and forwarded through an internal word FIFO with commit/rollback, so flagged-invalid packets are dropped. The control (DMA), match-engine and localbus ports are present for top-level compatibility but are not used.

Parameters:
DIRECT_MAC, 48'h000a35000001, DMAC forwarded to OUT_PORT
LOCAL_MAC, 48'h0023cd76631a, DMAC forwarded to the CPU (out field 12'h000)
OUT_PORT, 12'h001, out-port field for DIRECT_MAC hits
FIFO_AW, 9, data FIFO address width (512 words of 134 bits)
READY_TH, 128, minimum free words for pktin_ready=1

Ports:
clk in 1 clock
rst_n in 1 synchronous reset, active-HIGH (asserted when 1; the name is kept for codebase consistency)
pktin_data_wr in 1 input word strobe
pktin_data in 134 [133:132] 01=head/11=mid/10=tail; [131:128] invalid bytes in the last word; [127:0] data
pktin_data_valid in 1 packet-good flag, sampled when pktin_data_valid_wr=1
pktin_data_valid_wr in 1 strobe with the tail word
pktin_ready out 1 ingress may start a packet
pktout_data_wr out 1 output word strobe
pktout_data out 134 same format as pktin_data
pktout_data_valid out 1 always 1 on the tail
pktout_data_valid_wr out 1 pulses with the tail word
pktout_ready in 1 egress backpressure
um_timestamp in 64 unused
dma2um_data in 134, dma2um_data_wr in 1, dma2um_ready in 1: unused
um2dma_ready out 1 tied 1
um2dma_data out 134, um2dma_data_wr out 1: tied 0
um2me_key_wr out 1, um2me_key_valid out 1, um2match_key out 512, um2match_gme_alful out 1: tied 0
um2me_ready in 1, me2um_id_wr in 1, match2um_id in 16: unused
ctrl_valid in 1, ctrl2um_cs_n in 1, ctrl_cmd in 2, ctrl_datain in 32, ctrl_addr in 32: unused
um2ctrl_ack_n out 1 tied 1
ctrl_dataout out 32 tied 0
um_timer out 64 free-running cycle counter; 0 at reset; wraps

Behaviour:
- Reset (rst_n=1 at a clk edge): FIFO pointers=0, all state idle, all strobes 0, pktout_data=0, pktin_ready=1 on the next cycle, um_timer=0.
- Input word index k counts from 0 at the head word.
  - Word 0 (metadata0) and word 1 (metadata1) are held in registers and are not written to the FIFO yet.
  - Word 2 carries Ethernet fields: DMAC=[127:80], TPID=[31:16], PCP=[15:13].
- Word 0 rewrite:
  - Kept fields: [125:120] inport, [107:96] length, [95:88] SMID, [87:80].
  - [119:108] out field = OUT_PORT if DMAC==DIRECT_MAC; 12'h000 if DMAC==LOCAL_MAC; 12'hFFF otherwise.
  - [79:77] = PCP if TPID==16'h8100, else 0.
  - [76] = vlan-present flag.
- Write order: rewritten word 0, then word 1, in the cycle after word 2 arrives. Words 2 and later follow in order through a one-word skid.
- A packet that ends before word 2: out field 12'hFFF, PCP 0, flag 0.
- Commit and drop:
  - Write pointer is committed at the tail when pktin_data_valid=1.
  - On pktin_data_valid=0, the write pointer rolls back to the packet start and no output is produced.
  - If the FIFO fills mid-packet, the rest of the packet is discarded and rolled back at the tail.
- pktin_ready = 1 when free words >= READY_TH. Upstream checks it only before a head word; words within a packet are never refused.
- Read side:
  - Starts only when at least one committed packet exists (committed-packet counter > 0).
  - One word per cycle while pktout_ready=1; stalls, holding outputs, when pktout_ready=0.
  - pktout_ready is honoured on word boundaries.
- Tail output: pktout_data_valid=1 and pktout_data_valid_wr=1 for exactly that cycle.
- Latency: first output word no earlier than 3 cycles after the input tail.
- Back-to-back output packets are allowed with no gap.
- Simultaneous commit and read-start are allowed.
- Pointer arithmetic is modulo 2^FIFO_AW.

Test Plan:
- Example packet: inport 0, length 0x6e, SMID 0, DMAC 000a35000001, SMAC 0023cd76631a, tag 8100 with PCP 4, 7 words, tail [131:128]=2, valid=1. Required output word 0 = {2'b01,4'h0,128'h0000106e000198000000000000000000}; words 1–6 unchanged; valid_wr pulses with the tail.
- 50 back-to-back copies of that packet with 2-cycle gaps and pktout_ready=1 -> 50 identical output packets, no loss, pktin_ready stays 1.
- Same packet with pktin_data_valid=0 on the tail -> no output; the next good packet is output intact.
- DMAC=LOCAL_MAC and untagged -> out field 000, [79:76]=0.
- Unknown DMAC -> out field FFF.
- pktout_ready held 0 for 700 cycles with packets streaming in -> pktin_ready drops once free <128; after release, all committed packets drain in order.
- rst_n pulsed mid-packet -> no partial packet is output; a fresh packet afterwards is output correctly.
